// File: rtl/cell_test_sequencer.sv
// Stimulus/capture engine for a row of image-processor cells: switch-driven single
// transactions or an automatic opcode x colour sweep folded into a response checksum.
module cell_test_sequencer #(
    parameter int NUM_CELLS = 2,
    parameter int CHANNELS  = 3,
    parameter int CHAN_W    = 8,
    parameter int OPC_W     = 4,
    parameter int NUM_OPS   = 16,
    parameter int TIMEOUT   = 1023,
    localparam int PIX_W    = CHANNELS * CHAN_W,
    localparam int SEL_W    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
    input  logic                       SYSCLK,
    input  logic                       RST,
    input  logic [15:0]                sw,
    input  logic                       btn_next,
    input  logic                       btn_mode,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [PIX_W-1:0]           pix_a,
    output logic [PIX_W-1:0]           pix_b,
    output logic [OPC_W-1:0]           opcode,
    input  logic [NUM_CELLS-1:0]       rsp_valid,
    input  logic [NUM_CELLS*PIX_W-1:0] rsp_pixel,
    output logic [PIX_W-1:0]           disp_pixel,
    output logic [SEL_W-1:0]           disp_sel,
    output logic                       auto_mode,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [15:0]                checksum,
    output logic [15:0]                txn_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int REP_N = (CHAN_W + 3) / 4;
    localparam int PAD_W = ((PIX_W + 15) / 16) * 16;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t                     state_q, state_d;
    logic                       auto_q, auto_d;
    logic                       nextPrev_q, nextPrev_d;
    logic                       modePrev_q, modePrev_d;
    logic [11:0]                lastSw_q, lastSw_d;
    logic [3:0]                 aIdx_q, aIdx_d;
    logic [3:0]                 bIdx_q, bIdx_d;
    logic [OPC_W-1:0]           op_q, op_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [NUM_CELLS-1:0]       seen_q, seen_d;
    logic [NUM_CELLS*PIX_W-1:0] rsp_q, rsp_d;
    logic [15:0]                checksum_q, checksum_d;
    logic [15:0]                txnCount_q, txnCount_d;
    logic [PIX_W-1:0]           dispPixel_q, dispPixel_d;
    logic [SEL_W-1:0]           dispSel_q, dispSel_d;

    logic                       nextEdge, modeEdge, timedOut;
    logic [11:0]                swSel;
    logic [NUM_CELLS-1:0]       seenAll;
    logic                       unusedSwBits;

    // Palette index replicated MSB-first to fill a channel; every channel identical.
    function automatic logic [PIX_W-1:0] palette(input logic [3:0] idx);
        logic [4*REP_N-1:0] rep;
        rep = {REP_N{idx}};
        return {CHANNELS{rep[4*REP_N-1 -: CHAN_W]}};
    endfunction

    // Each cell result is zero-padded to whole 16-bit slices, and all slices are XORed.
    function automatic logic [15:0] fold(input logic [NUM_CELLS*PIX_W-1:0] rsp);
        logic [15:0]      acc;
        logic [PAD_W-1:0] cellPad;
        acc = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            cellPad = PAD_W'(rsp[k*PIX_W +: PIX_W]);
            for (int s = 0; s < PAD_W / 16; s++) begin
                acc = acc ^ cellPad[s*16 +: 16];
            end
        end
        return acc;
    endfunction

    assign nextEdge     = btn_next & ~nextPrev_q;
    assign modeEdge     = btn_mode & ~modePrev_q;
    assign swSel        = {sw[15:12], sw[7:0]};
    assign seenAll      = seen_q | rsp_valid;
    assign timedOut     = (timer_q == TMR_W'(TIMEOUT - 1));
    assign unusedSwBits = ^sw[11:8];

    always_ff @(posedge SYSCLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            auto_q      <= 1'b0;
            nextPrev_q  <= 1'b0;
            modePrev_q  <= 1'b0;
            lastSw_q    <= '0;
            aIdx_q      <= '0;
            bIdx_q      <= '0;
            op_q        <= '0;
            timer_q     <= '0;
            seen_q      <= '0;
            rsp_q       <= '0;
            checksum_q  <= '0;
            txnCount_q  <= '0;
            dispPixel_q <= '0;
            dispSel_q   <= '0;
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_d;
            nextPrev_q  <= nextPrev_d;
            modePrev_q  <= modePrev_d;
            lastSw_q    <= lastSw_d;
            aIdx_q      <= aIdx_d;
            bIdx_q      <= bIdx_d;
            op_q        <= op_d;
            timer_q     <= timer_d;
            seen_q      <= seen_d;
            rsp_q       <= rsp_d;
            checksum_q  <= checksum_d;
            txnCount_q  <= txnCount_d;
            dispPixel_q <= dispPixel_d;
            dispSel_q   <= dispSel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        auto_d      = auto_q;
        nextPrev_d  = btn_next;
        modePrev_d  = btn_mode;
        lastSw_d    = lastSw_q;
        aIdx_d      = aIdx_q;
        bIdx_d      = bIdx_q;
        op_d        = op_q;
        timer_d     = timer_q;
        seen_d      = seen_q;
        rsp_d       = rsp_q;
        checksum_d  = checksum_q;
        txnCount_d  = txnCount_q;
        dispPixel_d = dispPixel_q;
        dispSel_d   = dispSel_q;

        case (state_q)
            S_IDLE: begin
                // A mode edge wins over a simultaneous next edge and issues nothing.
                if (modeEdge) begin
                    auto_d = ~auto_q;
                end else if (auto_q) begin
                    if (nextEdge) begin
                        state_d    = S_ISSUE;
                        timer_d    = '0;
                        aIdx_d     = 4'h0;
                        bIdx_d     = 4'hF;
                        op_d       = '0;
                        checksum_d = '0;
                        txnCount_d = '0;
                    end
                end else if (nextEdge || (swSel != lastSw_q)) begin
                    state_d  = S_ISSUE;
                    timer_d  = '0;
                    aIdx_d   = sw[3:0];
                    bIdx_d   = sw[7:4];
                    op_d     = OPC_W'(sw[15:12]);
                    lastSw_d = swSel;
                    if (nextEdge) begin
                        dispSel_d = (dispSel_q == SEL_W'(NUM_CELLS - 1)) ? '0
                                                                          : dispSel_q + SEL_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                    seen_d  = '0;
                end else if (timedOut) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT: begin
                for (int k = 0; k < NUM_CELLS; k++) begin
                    if (rsp_valid[k]) begin
                        rsp_d[k*PIX_W +: PIX_W] = rsp_pixel[k*PIX_W +: PIX_W];
                    end
                end
                seen_d = seenAll;
                if (&seenAll) begin
                    state_d = S_CAPTURE;
                end else if (timedOut) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_CAPTURE: begin
                checksum_d = {checksum_q[14:0], checksum_q[15]} ^ fold(rsp_q);
                if (txnCount_q != 16'hFFFF) begin
                    txnCount_d = txnCount_q + 16'd1;
                end
                for (int k = 0; k < NUM_CELLS; k++) begin
                    if (dispSel_q == SEL_W'(k)) begin
                        dispPixel_d = rsp_q[k*PIX_W +: PIX_W];
                    end
                end
                if (!auto_q) begin
                    state_d = S_IDLE;
                end else if ((op_q == OPC_W'(NUM_OPS - 1)) && (aIdx_q == 4'hF)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                aIdx_d  = aIdx_q + 4'd1;
                bIdx_d  = 4'hF - (aIdx_q + 4'd1);
                op_d    = (aIdx_q == 4'hF) ? op_q + OPC_W'(1) : op_q;
                timer_d = '0;
                state_d = S_ISSUE;
            end
            S_DONE: begin
                if (modeEdge) begin
                    auto_d  = ~auto_q;
                    state_d = S_IDLE;
                end else if (nextEdge) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (modeEdge) begin
                    auto_d = ~auto_q;
                end else if (nextEdge) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_valid  = (state_q == S_ISSUE);
    assign pix_a      = palette(aIdx_q);
    assign pix_b      = palette(bIdx_q);
    assign opcode     = op_q;
    assign disp_pixel = dispPixel_q;
    assign disp_sel   = dispSel_q;
    assign auto_mode  = auto_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign checksum   = checksum_q;
    assign txn_count  = txnCount_q;

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Self-checking bench for cell_test_sequencer: emulated cells with configurable latency,
// a transaction-level reference model, table vectors, random vectors and corner sequences.
module tb_cell_test_sequencer;

    localparam int NC  = 2;
    localparam int PW  = 24;
    localparam int OPS = 2;
    localparam int TMO = 40;

    logic           clk = 1'b0;
    logic           rstN = 1'b0;
    logic [15:0]    sw = '0;
    logic           btnNext = 1'b0;
    logic           btnMode = 1'b0;
    logic           reqValid;
    logic           reqReady = 1'b1;
    logic [PW-1:0]  pixA, pixB;
    logic [3:0]     opcode;
    logic [NC-1:0]  rspValid = '0;
    logic [NC*PW-1:0] rspPixel = '0;
    logic [PW-1:0]  dispPixel;
    logic [0:0]     dispSel;
    logic           autoMode, busy, done, error;
    logic [15:0]    checksum, txnCount;

    int nChecks = 0;
    int nFail   = 0;

    cell_test_sequencer #(
        .NUM_CELLS(NC), .CHANNELS(3), .CHAN_W(8), .OPC_W(4), .NUM_OPS(OPS), .TIMEOUT(TMO)
    ) dut (
        .SYSCLK(clk), .RST(rstN), .sw(sw), .btn_next(btnNext), .btn_mode(btnMode),
        .req_valid(reqValid), .req_ready(reqReady), .pix_a(pixA), .pix_b(pixB),
        .opcode(opcode), .rsp_valid(rspValid), .rsp_pixel(rspPixel),
        .disp_pixel(dispPixel), .disp_sel(dispSel), .auto_mode(autoMode), .busy(busy),
        .done(done), .error(error), .checksum(checksum), .txn_count(txnCount)
    );

    always #5 clk = ~clk;

    // Emulated cells and reference model helpers
    function automatic logic [PW-1:0] pal(input int i);
        return 24'(i) * 24'h111111;
    endfunction

    function automatic logic [PW-1:0] cellFn(input int k, input logic [PW-1:0] pa,
                                             input logic [PW-1:0] pb, input logic [3:0] op,
                                             input bit echo);
        if (echo) return pa;
        return (pa + pb * 24'(k + 1)) ^ (24'(op) << (4 * k));
    endfunction

    function automatic logic [15:0] foldModel(input logic [PW-1:0] r);
        int          v;
        logic [15:0] x;
        v = int'(r);
        x = '0;
        while (v != 0) begin
            x = x ^ v[15:0];
            v = v >> 16;
        end
        return x;
    endfunction

    logic [15:0]   mCs = '0;
    int            mCnt = 0;
    int            mSel = 0;
    logic [PW-1:0] mDisp = '0;

    task automatic modelTxn(input logic [PW-1:0] r0, input logic [PW-1:0] r1);
        int c;
        c = ((int'(mCs) << 1) | (int'(mCs) >> 15)) & 16'hFFFF;
        mCs = 16'(c) ^ foldModel(r0) ^ foldModel(r1);
        if (mCnt < 65535) mCnt++;
        mDisp = (mSel == 0) ? r0 : r1;
    endtask

    // Cell responder: latency counted from the first WAIT cycle
    int            cfgDelay[NC];
    bit            cfgEn[NC];
    bit            cfgRand = 0;
    bit            cfgEcho = 1;
    int            cnt[NC];
    bit            armed[NC];
    logic [PW-1:0] pend[NC];
    bit            hsPending = 0;
    logic [PW-1:0] hsA, hsB;
    logic [3:0]    hsOp;
    int            hsCount = 0;

    always @(posedge clk) begin
        if (reqValid && reqReady) begin
            hsCount++;
            hsPending = 1;
            hsA  = pixA;
            hsB  = pixB;
            hsOp = opcode;
        end
    end

    always @(negedge clk) begin
        if (hsPending) begin
            hsPending = 0;
            for (int k = 0; k < NC; k++) begin
                armed[k] = cfgEn[k];
                cnt[k]   = cfgRand ? int'($urandom_range(0, 3)) : cfgDelay[k];
                pend[k]  = cellFn(k, hsA, hsB, hsOp, cfgEcho);
            end
        end
        for (int k = 0; k < NC; k++) begin
            rspValid[k] = 1'b0;
            if (armed[k]) begin
                if (cnt[k] == 0) begin
                    rspValid[k] = 1'b1;
                    rspPixel[k*PW +: PW] = pend[k];
                    armed[k] = 0;
                end else begin
                    cnt[k]--;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pulse(input bit n, input bit m);
        @(negedge clk);
        btnNext = n;
        btnMode = m;
        @(negedge clk);
        btnNext = 1'b0;
        btnMode = 1'b0;
    endtask

    // One manual transaction, started by a switch change or a btn_next pulse
    task automatic applyStimulus(input logic [15:0] swv, input bit useBtn, input int stall,
                                 input logic [PW-1:0] ea, input logic [PW-1:0] eb,
                                 input logic [3:0] eo, input string tag);
        int  hs0;
        bit  seen;
        bit  idle;
        hs0 = hsCount;
        @(negedge clk);
        reqReady = (stall == 0);
        sw = swv;
        if (useBtn) begin
            btnNext = 1'b1;
            mSel = (mSel + 1) % NC;
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            btnNext = 1'b0;
            seen = reqValid;
        end
        checkOutput({tag, " start"}, 128'(seen), 128'(1));
        if (seen) begin
            for (int i = 0; i <= stall; i++) begin
                if (i > 0) @(negedge clk);
                checkOutput({tag, " payload"}, {reqValid, pixA, pixB, opcode}, {1'b1, ea, eb, eo});
                if (i == stall) reqReady = 1'b1;
            end
            idle = 0;
            for (int i = 0; i < 60 && !idle; i++) begin
                @(negedge clk);
                idle = !busy;
            end
            checkOutput({tag, " finish"}, 128'(idle), 128'(1));
            modelTxn(cellFn(0, ea, eb, eo, cfgEcho), cellFn(1, ea, eb, eo, cfgEcho));
            checkOutput({tag, " disp_pixel"}, dispPixel, mDisp);
            checkOutput({tag, " disp_sel"}, dispSel, 128'(mSel));
            checkOutput({tag, " txn_count"}, txnCount, 128'(mCnt));
            checkOutput({tag, " checksum"}, checksum, mCs);
            checkOutput({tag, " wait entries"}, 128'(hsCount - hs0), 128'(1));
        end
        reqReady = 1'b1;
    endtask

    typedef struct {
        logic [15:0]   sw;
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [3:0]    op;
        logic [PW-1:0] disp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0]   swv;
        logic [PW-1:0] r0, r1;
        int            hs0;
        bit            got, early, reached;

        vecs[0] = '{16'h305A, 24'hAAAAAA, 24'h555555, 4'h3, 24'hAAAAAA};
        vecs[1] = '{16'hF0F0, 24'h000000, 24'hFFFFFF, 4'hF, 24'h000000};
        vecs[2] = '{16'h0712, 24'h222222, 24'h111111, 4'h0, 24'h222222};
        vecs[3] = '{16'h9C3F, 24'hFFFFFF, 24'h333333, 4'h9, 24'hFFFFFF};
        for (int k = 0; k < NC; k++) begin
            cfgDelay[k] = 0;
            cfgEn[k]    = 1;
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset outputs a", {reqValid, pixA, pixB, opcode, dispPixel}, '0);
        checkOutput("reset outputs b", {dispSel, autoMode, busy, done, error, checksum, txnCount}, '0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle after reset", {reqValid, busy, autoMode, txnCount}, '0);

        // Table vectors, cells echo pixel A
        cfgEcho = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].sw, 0, 0, vecs[i].a, vecs[i].b, vecs[i].op, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d table disp", i), dispPixel, vecs[i].disp);
        end

        // Random manual vectors against the model (opcode field kept below 8)
        cfgEcho = 0;
        cfgRand = 1;
        for (int i = 0; i < 8; i++) begin
            swv = 16'($urandom) & 16'h7FFF;
            while ({swv[15:12], swv[7:0]} == {sw[15:12], sw[7:0]}) swv = 16'($urandom) & 16'h7FFF;
            applyStimulus(swv, 0, 0, pal(int'(swv[3:0])), pal(int'(swv[7:4])), swv[15:12],
                          $sformatf("rand%0d", i));
        end

        // Ready held low for 5 cycles of ISSUE
        cfgRand = 0;
        applyStimulus(16'hB0C4, 0, 5, pal(4), pal(12), 4'hB, "stall");

        // Cell 1 strobes 3 cycles before cell 0, then both in the same cycle
        cfgDelay[0] = 3;
        cfgDelay[1] = 0;
        applyStimulus(16'h8071, 0, 0, pal(1), pal(7), 4'h8, "skew");
        cfgDelay[0] = 0;
        applyStimulus(16'hD0E2, 0, 0, pal(2), pal(14), 4'hD, "same-cycle");

        // btn_next in manual IDLE: repeats the transaction and advances disp_sel
        applyStimulus(16'hD0E2, 1, 0, pal(2), pal(14), 4'hD, "btn-next");

        // Simultaneous mode and next edges: mode toggles, nothing issued
        hs0 = hsCount;
        pulse(1, 1);
        repeat (3) @(negedge clk);
        checkOutput("dual edge auto_mode", autoMode, 128'(1));
        checkOutput("dual edge no txn", 128'(hsCount - hs0), 128'(0));
        checkOutput("dual edge disp_sel", dispSel, 128'(mSel));

        // Auto sweep with random cell latency
        cfgRand = 1;
        hs0 = hsCount;
        pulse(1, 0);
        mCs  = '0;
        mCnt = 0;
        for (int op = 0; op < OPS; op++) begin
            for (int a = 0; a < 16; a++) begin
                r0 = cellFn(0, pal(a), pal(15 - a), 4'(op), 0);
                r1 = cellFn(1, pal(a), pal(15 - a), 4'(op), 0);
                modelTxn(r0, r1);
            end
        end
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            reached = done;
        end
        checkOutput("auto done", 128'(reached), 128'(1));
        checkOutput("auto txn_count", txnCount, 128'(32));
        checkOutput("auto checksum", checksum, mCs);
        checkOutput("auto disp_pixel", dispPixel, mDisp);
        checkOutput("auto wait entries", 128'(hsCount - hs0), 128'(32));
        pulse(1, 0);
        checkOutput("auto exit", {done, busy}, '0);
        pulse(0, 1);
        checkOutput("back to manual", autoMode, 128'(0));

        // Cell 0 never responds: timeout exactly TMO cycles after WAIT entry
        cfgRand  = 0;
        cfgEn[0] = 0;
        hs0 = hsCount;
        @(negedge clk);
        sw = 16'hE036;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = (hsCount != hs0);
        end
        checkOutput("timeout handshake", 128'(got), 128'(1));
        early = 0;
        for (int i = 1; i <= TMO; i++) begin
            @(posedge clk);
            #1;
            if (i < TMO && error) early = 1;
        end
        checkOutput("timeout not early", 128'(early), 128'(0));
        checkOutput("timeout error", {error, reqValid, busy}, {1'b1, 1'b0, 1'b0});
        checkOutput("timeout keeps txn_count", txnCount, 128'(mCnt));
        checkOutput("timeout keeps checksum", checksum, mCs);
        pulse(1, 0);
        repeat (3) @(negedge clk);
        checkOutput("error cleared", {error, busy}, '0);
        checkOutput("no txn after clear", 128'(hsCount - hs0), 128'(1));
        cfgEn[0] = 1;

        // Reset in the middle of an auto-sweep WAIT
        pulse(0, 1);
        checkOutput("auto for reset", autoMode, 128'(1));
        cfgDelay[0] = 20;
        hs0 = hsCount;
        pulse(1, 0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = (hsCount != hs0);
        end
        checkOutput("reset txn handshake", 128'(got), 128'(1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("async reset a", {reqValid, pixA, pixB, opcode, dispPixel}, '0);
        checkOutput("async reset b", {dispSel, autoMode, busy, done, error, checksum, txnCount}, '0);
        sw = '0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("post reset idle", {autoMode, busy, error, done, checksum, txnCount}, '0);
        checkOutput("post reset no txn", 128'(hsCount - hs0), 128'(1));
        mCs  = '0;
        mCnt = 0;
        mSel = 0;
        cfgDelay[0] = 1;
        applyStimulus(16'h1234, 0, 0, pal(4), pal(3), 4'h1, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
